// File: rtl/duty_ramp_pkg.sv
// duty_ramp shared package: state encoding and default widths.
// Optional feature macro: DUTY_RAMP_CLAMP_EN (see rtl/duty_ramp.sv).
package duty_ramp_pkg;

  localparam int R_DEF        = 8;
  localparam int DIV_BITS_DEF = 15;

  localparam logic [R_DEF:0] FULL_SCALE_DEF = {1'b1, {R_DEF{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

endpackage

// File: rtl/duty_ramp_if.sv
// duty_ramp load interface: target/step/rate request with valid/ready.
// The master presents a request, the slave (the ramp) accepts it.
interface duty_ramp_if
  import duty_ramp_pkg::*;
#(
  parameter int R        = R_DEF,
  parameter int DIV_BITS = DIV_BITS_DEF
);

  logic [R:0]          target;
  logic [R:0]          step;
  logic [DIV_BITS-1:0] rate;
  logic                load_valid;
  logic                load_ready;

  modport master (
    output target, step, rate, load_valid,
    input  load_ready
  );

  modport slave (
    input  target, step, rate, load_valid,
    output load_ready
  );

endinterface

// File: rtl/duty_ramp_timer.sv
// ramp_interval_timer: enable-gated mod-(rate+1) counter.
// o_tick is high in the enabled cycle where the count equals rate.
module ramp_interval_timer #(
  parameter int DIV_BITS = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic [DIV_BITS-1:0] i_rate,
  output logic                o_tick
);

  logic [DIV_BITS-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_rate);

  // count 0..rate while enabled, wrap on tick, clear on request
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/duty_ramp.sv
// duty_ramp top: soft-start/fade slew of PWM duty toward a target.
// Define DUTY_RAMP_CLAMP_EN to clamp latched targets to full scale.
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int R        = R_DEF,
  parameter int DIV_BITS = DIV_BITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  duty_ramp_if.slave  lif,
  output logic [R:0]  duty,
  output logic        busy,
  output logic        done
);

  localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};

  state_e              r_state;
  logic [R:0]          r_duty;
  logic [R:0]          r_tgt;
  logic [R:0]          r_step;
  logic [DIV_BITS-1:0] r_rate;
  logic                r_done;
  logic                r_eq;

  logic       w_acc;
  logic       w_tick;
  logic [R:0] w_tgt;
  logic [R:0] w_diff;
  logic [R:0] w_amt;
  logic       w_last;

  assign lif.load_ready = (r_state == ST_IDLE);
  assign busy           = (r_state != ST_IDLE);
  assign duty           = r_duty;
  assign done           = r_done;
  assign w_acc          = lif.load_valid && lif.load_ready;

`ifdef DUTY_RAMP_CLAMP_EN
  assign w_tgt = (lif.target > FULL) ? FULL : lif.target;
`else
  assign w_tgt = lif.target;
`endif

  // distance to target is taken first, so the step never overshoots
  assign w_diff = (r_state == ST_UP) ? r_tgt - r_duty
                                     : r_duty - r_tgt;
  assign w_amt  = (r_step == '0 || r_step > w_diff) ? w_diff : r_step;
  assign w_last = (w_amt == w_diff);

  ramp_interval_timer #(
    .DIV_BITS (DIV_BITS)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_en   (enable && busy),
    .i_clr  (w_acc),
    .i_rate (r_rate),
    .o_tick (w_tick)
  );

  // FSM, request latch, duty update and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_tgt   <= '0;
      r_step  <= '0;
      r_rate  <= '0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
    end else begin
      r_done <= r_eq;
      r_eq   <= 1'b0;
      if (w_acc) begin
        r_tgt  <= w_tgt;
        r_step <= lif.step;
        r_rate <= lif.rate;
        if (w_tgt > r_duty) begin
          r_state <= ST_UP;
        end else if (w_tgt < r_duty) begin
          r_state <= ST_DOWN;
        end else begin
          r_eq <= 1'b1;
        end
      end else if (w_tick) begin
        if (r_state == ST_UP) begin
          r_duty <= r_duty + w_amt;
        end else begin
          r_duty <= r_duty - w_amt;
        end
        if (w_last) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp: directed self-checking bench for duty_ramp.
// Expected values are hand-computed from the ramp schedule.
module tb_duty_ramp;
  import duty_ramp_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [8:0] duty;
  logic       busy;
  logic       done;

  int n_asrt = 0;
  int n_fail = 0;

  duty_ramp_if lif ();

  duty_ramp dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .lif    (lif),
    .duty   (duty),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tck(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input int t, input int s, input int r);
    lif.target     = 9'(t);
    lif.step       = 9'(s);
    lif.rate       = 15'(r);
    lif.load_valid = 1'b1;
    tck(1);
    lif.load_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    lif.target     = '0;
    lif.step       = '0;
    lif.rate       = '0;
    lif.load_valid = 1'b0;
    tck(2);
    chk("rst_duty", int'(duty), 0);
    chk("rst_ready", int'(lif.load_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    tck(1);

    // ramp up 0 -> 100 by 10, every 4 edges
    req(100, 10, 3);
    chk("up_busy0", int'(busy), 1);
    chk("up_ready0", int'(lif.load_ready), 0);
    for (int u = 1; u <= 10; u++) begin
      tck(3);
      chk("up_hold", int'(duty), 10 * (u - 1));
      chk("up_nodone", int'(done), 0);
      tck(1);
      chk("up_duty", int'(duty), 10 * u);
      chk("up_done", int'(done), (u == 10) ? 1 : 0);
    end
    chk("up_busy_end", int'(busy), 0);
    chk("up_ready_end", int'(lif.load_ready), 1);
    tck(1);
    chk("up_done_once", int'(done), 0);

    // clipped final step from 0
    reset = 1'b1;
    tck(1);
    reset = 1'b0;
    req(25, 10, 0);
    chk("clip_d0", int'(duty), 0);
    tck(1);
    chk("clip_d1", int'(duty), 10);
    tck(1);
    chk("clip_d2", int'(duty), 20);
    chk("clip_nodone", int'(done), 0);
    tck(1);
    chk("clip_d3", int'(duty), 25);
    chk("clip_done", int'(done), 1);
    chk("clip_busy", int'(busy), 0);

    // jump up with step 0, then back-to-back ramp down with step 0
    req(100, 0, 0);
    chk("jump_busy", int'(busy), 1);
    tck(1);
    chk("jump_duty", int'(duty), 100);
    chk("jump_done", int'(done), 1);
    chk("b2b_ready", int'(lif.load_ready), 1);
    req(40, 0, 5);
    chk("dn_busy", int'(busy), 1);
    chk("dn_done_lo", int'(done), 0);
    tck(5);
    chk("dn_hold", int'(duty), 100);
    tck(1);
    chk("dn_duty", int'(duty), 40);
    chk("dn_done", int'(done), 1);

    // equal target: no busy, done one edge later
    req(40, 3, 2);
    chk("eq_busy", int'(busy), 0);
    chk("eq_done_lo", int'(done), 0);
    chk("eq_duty", int'(duty), 40);
    tck(1);
    chk("eq_done", int'(done), 1);
    chk("eq_busy2", int'(busy), 0);
    tck(1);
    chk("eq_done_off", int'(done), 0);

    // enable gap of 7 cycles plus an ignored request
    req(70, 10, 2);
    tck(2);
    chk("gap_pre", int'(duty), 40);
    enable = 1'b0;
    tck(2);
    lif.target     = 9'd0;
    lif.step       = 9'd0;
    lif.load_valid = 1'b1;
    tck(1);
    lif.load_valid = 1'b0;
    tck(4);
    chk("gap_hold", int'(duty), 40);
    chk("gap_busy", int'(busy), 1);
    enable = 1'b1;
    tck(1);
    chk("gap_u1", int'(duty), 50);
    tck(2);
    chk("gap_h2", int'(duty), 50);
    tck(1);
    chk("gap_u2", int'(duty), 60);
    tck(3);
    chk("gap_u3", int'(duty), 70);
    chk("gap_done", int'(done), 1);

    // reset mid-ramp discards the request
    req(200, 10, 1);
    tck(4);
    chk("mid_duty", int'(duty), 90);
    reset = 1'b1;
    tck(1);
    reset = 1'b0;
    chk("mrst_duty", int'(duty), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_ready", int'(lif.load_ready), 1);
    chk("mrst_done", int'(done), 0);
    tck(5);
    chk("mrst_stay", int'(duty), 0);

    // target beyond full scale
    req(300, 0, 0);
    tck(1);
`ifdef DUTY_RAMP_CLAMP_EN
    chk("clamp_duty", int'(duty), 256);
`else
    chk("clamp_duty", int'(duty), 300);
`endif
    chk("clamp_done", int'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
